hls_run_sequencer: RTL and testbench
====================================

# hls_run_sequencer

Synthesizable run controller for Bambu-generated accelerators (start_port/done_port protocol). It drives a DUT through a programmable number of back-to-back executions and resets the DUT before each one. It measures per-run latency in clock cycles, enforces a timeout, and streams one result record per run. It replaces the single-shot simulation-only harness FSM with an on-chip, multi-run sequencer usable in FPGA bring-up and in regression benches.

## Interface
- NUM_RUNS, 16: runs per campaign (≥1).
- CYC_W, 32: cycle counter width.
- TIMEOUT, 200000000: cycles allowed per run before abort (must fit CYC_W).
- RST_CYC, 2: DUT reset-low cycles before each run (≥1).
- GAP_CYC, 1: idle cycles between REPORT and the next DUT reset (≥0).

- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- go  in  1  start campaign; sampled in IDLE only.
- max_cycles  in  CYC_W  per-run latency bound; 0 disables the check. Sampled on go.
- dut_reset  out  1  active-low reset to the DUT.
- dut_start_port  out  1  one-cycle start pulse to the DUT.
- dut_done_port  in  1  DUT completion pulse.
- busy  out  1  campaign in progress.
- res_valid  out  1  one-cycle result strobe.
- res_run  out  $clog2(NUM_RUNS+1)  index of the reported run, 0-based.
- res_cycles  out  CYC_W  measured latency.
- res_status  out  2  00 pass, 01 over max_cycles, 10 timeout.
- campaign_done  out  1  one-cycle pulse at end of campaign.

## Operation
- States: IDLE, DRST, START, WAIT, REPORT, GAP, FIN.
- IDLE: dut_reset=1, busy=0. go=1 latches max_cycles, clears run index and timeout flag, then goes to DRST.
- DRST: dut_reset=0 for RST_CYC cycles, then goes to START.
- START: dut_start_port=1 for exactly one cycle. The cycle counter loads 1. If dut_done_port=1 in this same cycle, go to REPORT with cycles=1. Otherwise go to WAIT.
- WAIT: counter increments each cycle. The counter value in the cycle where dut_done_port is sampled high is the latency, counted inclusive of the start cycle. If the counter reaches TIMEOUT with no done, status=10, go to REPORT, and set the abort flag.
- REPORT: res_valid=1 for one cycle with res_run, res_cycles, and res_status. res_status=01 if max_cycles≠0 and cycles>max_cycles; otherwise 00, unless the run timed out.
  - If the abort flag is set or this was the last run (index NUM_RUNS-1), go to FIN.
  - Otherwise increment the index and go to GAP. If GAP_CYC=0, go straight to DRST.
- GAP: GAP_CYC idle cycles with dut_reset=1, then go to DRST.
- FIN: campaign_done=1 for one cycle; dut_reset=0 if aborted, else 1. Then go to IDLE. After an abort, the DUT is held in reset until the next go.
- dut_done_port is ignored outside START and WAIT; stray pulses have no effect.
- go is ignored while busy.
- Counter saturates at all-ones and never wraps.
- res_* holds its last values while res_valid=0.

## Timing
- Reset (reset=0 at a rising edge) gives, on the next cycle: state IDLE, dut_reset=0, dut_start_port=0, busy=0, res_valid=0, res_run=0, res_cycles=0, res_status=00, campaign_done=0. After reset deasserts, dut_reset returns to 1 in IDLE.
- Reset mid-campaign aborts immediately. No REPORT or campaign_done is emitted.
- go→first dut_start_port: 1 + RST_CYC cycles.
- done sampled high→res_valid: next cycle.
- res_valid→next dut_start_port: GAP_CYC + RST_CYC + 1 cycles.
- Last REPORT→campaign_done: next cycle. busy deasserts in the cycle after campaign_done.
- All outputs are registered.

## Test plan
- NUM_RUNS=3, RST_CYC=2, GAP_CYC=1; the DUT model asserts done 10 cycles after start (start counts as cycle 1). Expected: three res_valid pulses, each with cycles=10 and status 00, run 0,1,2, start pulses 14 cycles apart, then one campaign_done.
- The DUT raises done in the same cycle as start. Expected: cycles=1, status 00.
- TIMEOUT=50 and the DUT never responds. Expected: one record with cycles=50 and status 10, then campaign_done, with dut_reset held low in IDLE. Run 1 never starts.
- max_cycles=8 with a DUT latency of 9. Expected: status 01 on every run and the campaign completes all runs.
- Reset pulsed low during WAIT of run 1. Expected: all outputs at reset values next cycle, no further res_valid, and a subsequent go restarts at run 0.
- go pulsed in WAIT, plus a stray done during GAP. Expected: both ignored, with the record count and timings unchanged.

Source files
------------

// File: rtl/hls_run_sequencer.sv
// hls_run_sequencer: multi-run controller for start_port/done_port accelerators.
// Resets the DUT before each run, pulses start, measures the latency
// (start cycle counts as 1), enforces a timeout and emits one result record per run.
module hls_run_sequencer #(
    parameter int NUM_RUNS = 16,
    parameter int CYC_W    = 32,
    parameter int TIMEOUT  = 200000000,
    parameter int RST_CYC  = 2,
    parameter int GAP_CYC  = 1
) (
    input  logic                               i_clock,
    input  logic                               i_reset,
    input  logic                               i_go,
    input  logic [CYC_W-1:0]                   i_max_cycles,
    output logic                               o_dut_reset,
    output logic                               o_dut_start_port,
    input  logic                               i_dut_done_port,
    output logic                               o_busy,
    output logic                               o_res_valid,
    output logic [$clog2(NUM_RUNS+1)-1:0]      o_res_run,
    output logic [CYC_W-1:0]                   o_res_cycles,
    output logic [1:0]                         o_res_status,
    output logic                               o_campaign_done
);

    localparam int RUN_W    = $clog2(NUM_RUNS + 1);
    localparam int TMR_MAX  = (RST_CYC > GAP_CYC) ? RST_CYC : GAP_CYC;
    localparam int TMR_W    = (TMR_MAX > 1) ? $clog2(TMR_MAX + 1) : 1;
    localparam int GAP_LD_I = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    localparam logic [TMR_W-1:0] RST_LOAD  = TMR_W'(RST_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_LD_I);
    localparam logic [CYC_W-1:0] TIMEOUT_C = CYC_W'(TIMEOUT);
    localparam logic [RUN_W-1:0] LAST_RUN  = RUN_W'(NUM_RUNS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DRST, S_START, S_WAIT, S_REPORT, S_GAP, S_FIN
    } state_t;

    state_t             r_state;
    logic [TMR_W-1:0]   r_tmr;
    logic [CYC_W-1:0]   r_cnt;
    logic [RUN_W-1:0]   r_run;
    logic               r_abort;
    logic [CYC_W-1:0]   r_max;
    logic               r_dut_reset;
    logic               r_start;
    logic               r_busy;
    logic               r_res_valid;
    logic [RUN_W-1:0]   r_res_run;
    logic [CYC_W-1:0]   r_res_cycles;
    logic [1:0]         r_res_status;
    logic               r_cdone;

    state_t             w_state_next;
    logic [TMR_W-1:0]   w_tmr_next;
    logic [CYC_W-1:0]   w_cnt_next;
    logic [RUN_W-1:0]   w_run_next;
    logic               w_abort_next;
    logic [CYC_W-1:0]   w_max_next;
    logic               w_dut_reset_next;
    logic               w_start_next;
    logic               w_busy_next;
    logic               w_res_valid_next;
    logic [RUN_W-1:0]   w_res_run_next;
    logic [CYC_W-1:0]   w_res_cycles_next;
    logic [1:0]         w_res_status_next;
    logic               w_cdone_next;
    logic               w_over;

    // Latency bound is only enforced when a nonzero max was latched on go.
    assign w_over = (r_max != '0) && (r_cnt > r_max);

    // Next-state, datapath and next-output decode; outputs follow the next state so they are registered.
    always_comb begin
        w_state_next      = r_state;
        w_tmr_next        = r_tmr;
        w_cnt_next        = r_cnt;
        w_run_next        = r_run;
        w_abort_next      = r_abort;
        w_max_next        = r_max;
        w_res_run_next    = r_res_run;
        w_res_cycles_next = r_res_cycles;
        w_res_status_next = r_res_status;

        case (r_state)
            S_IDLE: begin
                if (i_go) begin
                    w_max_next   = i_max_cycles;
                    w_run_next   = '0;
                    w_abort_next = 1'b0;
                    w_tmr_next   = RST_LOAD;
                    w_state_next = S_DRST;
                end
            end
            S_DRST: begin
                if (r_tmr == '0) begin
                    w_state_next = S_START;
                    w_cnt_next   = CYC_W'(1);
                end else begin
                    w_tmr_next = r_tmr - TMR_W'(1);
                end
            end
            S_START, S_WAIT: begin
                // A done in the same cycle as the timeout limit still counts as a pass.
                if (i_dut_done_port) begin
                    w_state_next      = S_REPORT;
                    w_res_run_next    = r_run;
                    w_res_cycles_next = r_cnt;
                    w_res_status_next = w_over ? 2'b01 : 2'b00;
                end else if (r_cnt >= TIMEOUT_C) begin
                    w_state_next      = S_REPORT;
                    w_res_run_next    = r_run;
                    w_res_cycles_next = r_cnt;
                    w_res_status_next = 2'b10;
                    w_abort_next      = 1'b1;
                end else begin
                    w_state_next = S_WAIT;
                    if (r_cnt != '1) begin
                        w_cnt_next = r_cnt + CYC_W'(1);
                    end
                end
            end
            S_REPORT: begin
                if (r_abort || (r_run == LAST_RUN)) begin
                    w_state_next = S_FIN;
                end else begin
                    w_run_next = r_run + RUN_W'(1);
                    if (GAP_CYC == 0) begin
                        w_state_next = S_DRST;
                        w_tmr_next   = RST_LOAD;
                    end else begin
                        w_state_next = S_GAP;
                        w_tmr_next   = GAP_LOAD;
                    end
                end
            end
            S_GAP: begin
                if (r_tmr == '0) begin
                    w_state_next = S_DRST;
                    w_tmr_next   = RST_LOAD;
                end else begin
                    w_tmr_next = r_tmr - TMR_W'(1);
                end
            end
            S_FIN: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        w_busy_next      = (w_state_next != S_IDLE);
        w_start_next     = (w_state_next == S_START);
        w_res_valid_next = (w_state_next == S_REPORT);
        w_cdone_next     = (w_state_next == S_FIN);
        // After an abort the DUT stays in reset through FIN and IDLE until the next go.
        case (w_state_next)
            S_DRST:         w_dut_reset_next = 1'b0;
            S_IDLE, S_FIN:  w_dut_reset_next = ~w_abort_next;
            default:        w_dut_reset_next = 1'b1;
        endcase
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_tmr        <= '0;
            r_cnt        <= '0;
            r_run        <= '0;
            r_abort      <= 1'b0;
            r_max        <= '0;
            r_dut_reset  <= 1'b0;
            r_start      <= 1'b0;
            r_busy       <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_run    <= '0;
            r_res_cycles <= '0;
            r_res_status <= 2'b00;
            r_cdone      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_tmr        <= w_tmr_next;
            r_cnt        <= w_cnt_next;
            r_run        <= w_run_next;
            r_abort      <= w_abort_next;
            r_max        <= w_max_next;
            r_dut_reset  <= w_dut_reset_next;
            r_start      <= w_start_next;
            r_busy       <= w_busy_next;
            r_res_valid  <= w_res_valid_next;
            r_res_run    <= w_res_run_next;
            r_res_cycles <= w_res_cycles_next;
            r_res_status <= w_res_status_next;
            r_cdone      <= w_cdone_next;
        end
    end

    assign o_dut_reset      = r_dut_reset;
    assign o_dut_start_port = r_start;
    assign o_busy           = r_busy;
    assign o_res_valid      = r_res_valid;
    assign o_res_run        = r_res_run;
    assign o_res_cycles     = r_res_cycles;
    assign o_res_status     = r_res_status;
    assign o_campaign_done  = r_cdone;

endmodule

// File: tb/tb_hls_run_sequencer.sv
// Testbench for hls_run_sequencer: table of campaigns against a behavioural
// fixed-latency DUT model, plus hand-written reset-mid-run sequence.
module tb_hls_run_sequencer;

    localparam int NR = 3;
    localparam int CW = 32;
    localparam int TO = 50;
    localparam int RC = 2;
    localparam int GC = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          go_drv;
    logic          go_inj = 1'b0;
    logic          go_w;
    logic [CW-1:0] max_cycles;
    logic          dut_reset;
    logic          dut_start;
    logic          done;
    logic          model_done;
    logic          stray = 1'b0;
    logic          stray_pend = 1'b0;
    logic          busy;
    logic          res_valid;
    logic [1:0]    res_run;
    logic [CW-1:0] res_cycles;
    logic [1:0]    res_status;
    logic          cdone;

    always #5 clk = ~clk;

    assign go_w = go_drv | go_inj;
    assign done = model_done | stray;

    hls_run_sequencer #(
        .NUM_RUNS(NR), .CYC_W(CW), .TIMEOUT(TO), .RST_CYC(RC), .GAP_CYC(GC)
    ) dut (
        .i_clock(clk),
        .i_reset(rst_n),
        .i_go(go_w),
        .i_max_cycles(max_cycles),
        .o_dut_reset(dut_reset),
        .o_dut_start_port(dut_start),
        .i_dut_done_port(done),
        .o_busy(busy),
        .o_res_valid(res_valid),
        .o_res_run(res_run),
        .o_res_cycles(res_cycles),
        .o_res_status(res_status),
        .o_campaign_done(cdone)
    );

    // Behavioural accelerator: done in cycle number m_lat counted from start (=1); 0 never answers.
    int m_lat = 0;
    int m_age = 0;
    always @(posedge clk) begin
        if (!dut_reset)                      m_age <= 0;
        else if (dut_start)                  m_age <= 2;
        else if (m_age != 0 && m_age < 1000) m_age <= m_age + 1;
    end
    assign model_done = (m_lat != 0) &&
                        ((dut_start && m_lat == 1) || (!dut_start && m_age == m_lat));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int run;
        int cycles;
        int status;
        int cyc;
    } rec_t;

    rec_t recs_q[$];
    int   starts_q[$];
    int   cd_cnt = 0;

    // Event monitor, sampled on the falling edge.
    always @(negedge clk) begin
        rec_t r;
        if (dut_start) starts_q.push_back(cyc);
        if (res_valid) begin
            r.run    = int'(res_run);
            r.cycles = int'(res_cycles);
            r.status = int'(res_status);
            r.cyc    = cyc;
            recs_q.push_back(r);
            $display("record: run=%0d cycles=%0d status=%0d at cycle %0d", r.run, r.cycles, r.status, cyc);
        end
        if (cdone) cd_cnt <= cd_cnt + 1;
    end

    // Disturbance injector: go four cycles after each start (inside WAIT) and a stray done in GAP.
    bit inj_en = 1'b0;
    int go_dly = 0;
    always @(negedge clk) begin
        go_inj     <= 1'b0;
        stray      <= stray_pend;
        stray_pend <= inj_en && res_valid;
        if (inj_en && dut_start) go_dly <= 4;
        else if (go_dly != 0)    go_dly <= go_dly - 1;
        if (go_dly == 1)         go_inj <= 1'b1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".dut_reset"},  dut_reset,  0);
        chk({tag, ".start"},      dut_start,  0);
        chk({tag, ".busy"},       busy,       0);
        chk({tag, ".res_valid"},  res_valid,  0);
        chk({tag, ".res_run"},    res_run,    0);
        chk({tag, ".res_cycles"}, res_cycles, 0);
        chk({tag, ".res_status"}, res_status, 0);
        chk({tag, ".cdone"},      cdone,      0);
    endtask

    typedef struct {
        int lat;
        int maxc;
        bit inj;
        int nrec;
        int cycles;
        int status;
        bit abort;
    } vec_t;

    vec_t tbl[9];

    task automatic run_vec(input int v);
        vec_t  t;
        int    go_cyc;
        int    cd_cyc;
        bit    seen;
        string tag;
        t      = tbl[v];
        tag    = $sformatf("v%0d", v);
        m_lat      = t.lat;
        max_cycles = CW'(t.maxc);
        inj_en     = t.inj;
        cd_cyc     = 0;
        @(negedge clk);
        starts_q.delete();
        recs_q.delete();
        cd_cnt = 0;
        go_drv = 1'b1;
        go_cyc = cyc;
        @(negedge clk);
        go_drv = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (cdone) begin
                seen   = 1'b1;
                cd_cyc = cyc;
                chk({tag, ".busy_at_done"}, busy, 1);
            end
        end
        chk({tag, ".campaign_done_seen"}, seen, 1);
        @(negedge clk);
        inj_en = 1'b0;
        chk({tag, ".busy_after"},      busy,       0);
        chk({tag, ".cdone_one_cycle"}, cdone,      0);
        chk({tag, ".idle_dut_reset"},  dut_reset,  t.abort ? 0 : 1);
        chk({tag, ".hold_cycles"},     res_cycles, t.cycles);
        chk({tag, ".hold_status"},     res_status, t.status);
        chk({tag, ".rec_count"},       recs_q.size(),   t.nrec);
        chk({tag, ".start_count"},     starts_q.size(), t.nrec);
        chk({tag, ".cdone_count"},     cd_cnt,     1);
        if (starts_q.size() > 0)
            chk({tag, ".go_to_start"}, starts_q[0] - go_cyc, 1 + RC);
        for (int i = 0; i < recs_q.size() && i < t.nrec; i++) begin
            chk($sformatf("%s.r%0d.run", tag, i),    recs_q[i].run,    i);
            chk($sformatf("%s.r%0d.cycles", tag, i), recs_q[i].cycles, t.cycles);
            chk($sformatf("%s.r%0d.status", tag, i), recs_q[i].status, t.status);
            if (i < starts_q.size())
                chk($sformatf("%s.r%0d.latency", tag, i), recs_q[i].cyc - starts_q[i], t.cycles);
            if (i > 0 && i < starts_q.size())
                chk($sformatf("%s.r%0d.spacing", tag, i), starts_q[i] - starts_q[i-1], t.cycles + GC + RC + 1);
        end
        if (recs_q.size() > 0)
            chk({tag, ".report_to_cdone"}, cd_cyc - recs_q[recs_q.size()-1].cyc, 1);
        if (t.abort) begin
            repeat (5) @(negedge clk);
            chk({tag, ".abort_hold_reset"}, dut_reset, 0);
        end
    endtask

    initial begin
        int  n;
        bit  reached;
        //          lat maxc inj nrec cyc st abort
        tbl[0] = '{10,  0,  0,  3,  10, 0, 0};
        tbl[1] = '{10,  0,  1,  3,  10, 0, 0};
        tbl[2] = '{ 1,  0,  0,  3,   1, 0, 0};
        tbl[3] = '{ 0,  0,  0,  1,  50, 2, 1};
        tbl[4] = '{ 9,  8,  0,  3,   9, 1, 0};
        tbl[5] = '{ 8,  8,  0,  3,   8, 0, 0};
        tbl[6] = '{50,  0,  0,  3,  50, 0, 0};
        tbl[7] = '{51,  0,  0,  1,  50, 2, 1};
        tbl[8] = '{ 2,  1,  0,  3,   2, 1, 0};

        rst_n      = 1'b0;
        go_drv     = 1'b0;
        max_cycles = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        rst_n = 1'b1;
        @(negedge clk);
        chk("por.idle_dut_reset", dut_reset, 1);

        for (int v = 0; v < 9; v++) run_vec(v);

        // Reset pulsed during WAIT of run 1.
        m_lat      = 10;
        max_cycles = '0;
        @(negedge clk);
        starts_q.delete();
        recs_q.delete();
        go_drv = 1'b1;
        @(negedge clk);
        go_drv  = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 500 && !reached; i++) begin
            @(negedge clk);
            if (starts_q.size() >= 2) reached = 1'b1;
        end
        chk("mid.reached_run1", reached, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("mid");
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid.idle_dut_reset", dut_reset, 1);
        chk("mid.busy", busy, 0);
        n      = recs_q.size();
        cd_cnt = 0;
        repeat (40) @(negedge clk);
        chk("mid.no_more_records", recs_q.size(), n);
        chk("mid.no_cdone", cd_cnt, 0);
        run_vec(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
